// File: rtl/ResetPkg.sv
// Shared types and constants for the reset request generator.
package ResetPkg;

    typedef enum logic [1:0] {
        POR    = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int unsigned CAUSE_W   = 4;
    localparam int unsigned CAUSE_POR = 0;
    localparam int unsigned CAUSE_EXT = 1;
    localparam int unsigned CAUSE_SW  = 2;
    localparam int unsigned CAUSE_WDT = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_RESET = 4'b0001;

endpackage

// File: rtl/reset_request_generator_sync_chain.sv
// Multi-flop synchronizer with selectable reset value and reset polarity.
module sync_chain #(
    parameter int unsigned STAGES         = 2,
    parameter logic        RST_VAL        = 1'b0,
    parameter bit          RST_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    generate
        if (RST_ACTIVE_LOW) begin : g_rst_low
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) chain <= {STAGES{RST_VAL}};
                else      chain <= {chain[STAGES-2:0], d};
            end
        end else begin : g_rst_high
            always_ff @(posedge clk or posedge rst) begin
                if (rst) chain <= {STAGES{RST_VAL}};
                else     chain <= {chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_request_generator.sv
// Merges POR, debounced button, software and watchdog resets into one
// minimum-width reset request, and records a sticky reset cause.
module reset_request_generator
    import ResetPkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned REQ_CYCLES      = 4,
    parameter int unsigned WDT_CYCLES      = 1000
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               extResetN,
    input  logic               swResetReq,
    input  logic               wdtEnable,
    input  logic               wdtKick,
    input  logic               causeClear,
    output logic               rstReq,
    output logic [CAUSE_W-1:0] resetCause
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PULSE_W = $clog2(REQ_CYCLES + 1);
    localparam int unsigned WDT_W   = $clog2(WDT_CYCLES);

    localparam logic [PULSE_W-1:0] PULSE_RELOAD = PULSE_W'(REQ_CYCLES - 1);
    localparam logic [WDT_W-1:0]   WDT_RELOAD   = WDT_W'(WDT_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_TARGET    = DB_W'(DEBOUNCE_CYCLES);

    logic               rst_int_n;
    logic               ext_sync;
    logic               deb_level;
    logic               deb_level_d;
    logic [DB_W-1:0]    db_cnt;
    logic [DB_W-1:0]    db_inc;
    logic               db_flip;
    logic [WDT_W-1:0]   wdt_cnt;
    logic               wdt_fire;
    logic               ext_press;
    logic [CAUSE_W-1:0] evt;
    state_t             state, state_next;
    logic [PULSE_W-1:0] pulse_cnt, pulse_next;
    logic [CAUSE_W-1:0] cause_next;
    logic               req_next;

    // Internal reset: asserts with rstN, releases synchronously.
    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .RST_ACTIVE_LOW(1'b1)) u_rst_sync (
        .clk (clk),
        .rst (rstN),
        .d   (1'b1),
        .q   (rst_int_n)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .RST_ACTIVE_LOW(1'b1)) u_ext_sync (
        .clk (clk),
        .rst (rstN),
        .d   (extResetN),
        .q   (ext_sync)
    );

    // Debounce: level flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        db_inc  = (db_cnt == DB_TARGET) ? db_cnt : db_cnt + DB_W'(1);
        db_flip = (ext_sync != deb_level) && (db_inc == DB_TARGET);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            deb_level   <= 1'b1;
            deb_level_d <= 1'b1;
            db_cnt      <= '0;
        end else begin
            deb_level_d <= deb_level;
            if (ext_sync == deb_level) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                deb_level <= ext_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_inc;
            end
        end
    end

    // Watchdog only runs in RUN; a kick always beats expiry.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wdt_cnt <= WDT_RELOAD;
        end else if (state != RUN || !wdtEnable || wdtKick) begin
            wdt_cnt <= WDT_RELOAD;
        end else if (wdt_cnt != '0) begin
            wdt_cnt <= wdt_cnt - WDT_W'(1);
        end
    end

    always_comb begin
        wdt_fire  = (state == RUN) && wdtEnable && !wdtKick && (wdt_cnt == '0);
        ext_press = (state == RUN) && deb_level_d && !deb_level;
        evt            = '0;
        evt[CAUSE_EXT] = ext_press;
        evt[CAUSE_SW]  = (state == RUN) && swResetReq;
        evt[CAUSE_WDT] = wdt_fire;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= POR;
            pulse_cnt  <= PULSE_RELOAD;
            rstReq     <= 1'b1;
            resetCause <= CAUSE_RESET;
        end else begin
            state      <= state_next;
            pulse_cnt  <= pulse_next;
            rstReq     <= req_next;
            resetCause <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        pulse_next = pulse_cnt;
        cause_next = resetCause;
        case (state)
            POR: state_next = ASSERT;
            ASSERT: begin
                if (pulse_cnt == '0) state_next = deb_level ? RUN : HOLD;
                else                 pulse_next = pulse_cnt - PULSE_W'(1);
            end
            HOLD: if (deb_level) state_next = RUN;
            RUN: begin
                if (evt != '0) begin
                    state_next = ASSERT;
                    pulse_next = PULSE_RELOAD;
                end
            end
            default: state_next = POR;
        endcase
        // New event bits survive a simultaneous clear.
        if (evt != '0)
            cause_next = (causeClear ? '0 : resetCause) | evt;
        else if (causeClear && state != POR)
            cause_next = '0;
        req_next = (state_next != RUN);
    end

endmodule

// File: tb/tb_reset_request_generator.sv
// Scoreboard bench: expected rstReq/resetCause values are queued per cycle.
module tb_reset_request_generator;

    logic       clk = 1'b0;
    logic       rstN;
    logic       extResetN;
    logic       swResetReq;
    logic       wdtEnable;
    logic       wdtKick;
    logic       causeClear;
    logic       rstReq;
    logic [3:0] resetCause;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        bit         sig;
        logic [3:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    reset_request_generator #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .REQ_CYCLES(4), .WDT_CYCLES(1000)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .extResetN  (extResetN),
        .swResetReq (swResetReq),
        .wdtEnable  (wdtEnable),
        .wdtKick    (wdtKick),
        .causeClear (causeClear),
        .rstReq     (rstReq),
        .resetCause (resetCause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic exp_at(input int c, input bit sig, input logic [3:0] v, input string tag);
        exp_t e;
        e.cyc = c; e.sig = sig; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_range(input int c0, input int c1, input bit sig,
                             input logic [3:0] v, input string tag);
        for (int c = c0; c <= c1; c++) exp_at(c, sig, v, tag);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("sb_drain", 4'(sb.size() > 0), 4'd0);
        sb.delete();
    endtask

    // Compare every queued expectation due this cycle; stale ones are failures.
    always @(negedge clk) begin : monitor
        int i;
        logic [3:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                got = sb[i].sig ? resetCause : {3'b000, rstReq};
                check(sb[i].tag, got, sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                check({sb[i].tag, "_stale"}, 4'hF, sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic por_release(input string tag);
        int r;
        r = cyc;
        exp_range(r + 1, r + 6, 1'b0, 4'd1, {tag, "_req"});
        exp_at(r + 7, 1'b0, 4'd0, {tag, "_fall"});
        exp_range(r + 1, r + 7, 1'b1, 4'b0001, {tag, "_cause"});
        rstN = 1'b1;
        drain();
    endtask

    initial begin : timeout
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s, b, f, w, k;
        rstN       = 1'b0;
        extResetN  = 1'b1;
        swResetReq = 1'b0;
        wdtEnable  = 1'b0;
        wdtKick    = 1'b0;
        causeClear = 1'b0;

        // Power-on
        @(negedge clk);
        s = cyc;
        exp_range(s + 1, s + 4, 1'b0, 4'd1, "por_hold_req");
        exp_range(s + 1, s + 4, 1'b1, 4'b0001, "por_hold_cause");
        repeat (5) @(negedge clk);
        por_release("por");

        // Software reset; second pulse inside ASSERT is ignored
        s = cyc;
        exp_at(s + 1, 1'b1, 4'b0000, "sw_clr");
        causeClear = 1'b1;
        @(negedge clk);
        causeClear = 1'b0;
        s = cyc;
        exp_range(s + 1, s + 4, 1'b0, 4'd1, "sw_req");
        exp_at(s + 5, 1'b0, 4'd0, "sw_fall");
        exp_range(s + 1, s + 5, 1'b1, 4'b0100, "sw_cause");
        swResetReq = 1'b1;
        @(negedge clk);
        swResetReq = 1'b0;
        @(negedge clk);
        swResetReq = 1'b1;
        @(negedge clk);
        swResetReq = 1'b0;
        drain();

        // Button: short bounce rejected
        b = cyc;
        exp_at(b + 1, 1'b1, 4'b0000, "bnc_clr");
        exp_range(b + 1, b + 25, 1'b0, 4'd0, "bnc_req");
        causeClear = 1'b1;
        extResetN  = 1'b0;
        @(negedge clk);
        causeClear = 1'b0;
        wait_cyc(b + 5);
        extResetN = 1'b1;
        drain();

        // Button: long press, HOLD until debounced release
        f = cyc;
        exp_range(f + 1, f + 10, 1'b0, 4'd0, "btn_pre");
        exp_range(f + 11, f + 40, 1'b0, 4'd1, "btn_req");
        exp_at(f + 41, 1'b0, 4'd0, "btn_fall");
        exp_at(f + 11, 1'b1, 4'b0010, "btn_cause");
        extResetN = 1'b0;
        wait_cyc(f + 30);
        extResetN = 1'b1;
        drain();

        // Watchdog expiry without kicks
        w = cyc;
        exp_at(w + 1, 1'b1, 4'b0000, "wdt_clr");
        exp_range(w + 1, w + 999, 1'b0, 4'd0, "wdt_pre");
        exp_range(w + 1000, w + 1003, 1'b0, 4'd1, "wdt_req");
        exp_at(w + 1004, 1'b0, 4'd0, "wdt_fall");
        exp_at(w + 1000, 1'b1, 4'b1000, "wdt_cause");
        causeClear = 1'b1;
        wdtEnable  = 1'b1;
        @(negedge clk);
        causeClear = 1'b0;
        wait_cyc(w + 1004);
        wdtEnable = 1'b0;
        drain();

        // Kicks every 999 cycles, then a kick exactly at counter zero
        k = cyc;
        exp_range(k + 1, k + 3010, 1'b0, 4'd0, "kick_req");
        exp_at(k + 3010, 1'b1, 4'b1000, "kick_cause");
        wdtEnable = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_cyc(k + ((j == 2) ? 2998 : 999 * (j + 1)) - 1);
            wdtKick = 1'b1;
            @(negedge clk);
            wdtKick = 1'b0;
        end
        wait_cyc(k + 3010);
        wdtEnable = 1'b0;
        drain();

        // Simultaneous sw + watchdog with clear
        w = cyc;
        exp_at(w + 999, 1'b0, 4'd0, "sim_pre");
        exp_range(w + 1000, w + 1003, 1'b0, 4'd1, "sim_req");
        exp_at(w + 1004, 1'b0, 4'd0, "sim_fall");
        exp_at(w + 1000, 1'b1, 4'b1100, "sim_cause");
        wdtEnable = 1'b1;
        wait_cyc(w + 999);
        swResetReq = 1'b1;
        causeClear = 1'b1;
        @(negedge clk);
        swResetReq = 1'b0;
        causeClear = 1'b0;
        wdtEnable  = 1'b0;
        drain();

        // Async reset in the middle of ASSERT
        s = cyc;
        exp_at(s + 1, 1'b1, 4'b1100, "mid_pre_cause");
        exp_range(s + 1, s + 5, 1'b0, 4'd1, "mid_req");
        swResetReq = 1'b1;
        @(negedge clk);
        swResetReq = 1'b0;
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        check("async_req", {3'b000, rstReq}, 4'd1);
        check("async_cause", resetCause, 4'b0001);
        wait_cyc(s + 5);
        por_release("por2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
